sr595_chain_ctrl: RTL and testbench
===================================

# sr595_chain_ctrl

Parametrised driver for a daisy-chain of 74HC595 shift registers: accepts a word over a valid/ready handshake, serialises it on DS/SHCP at a programmable bit rate, pulses STCP to latch, and drives OE. It generalises the single-word 595 controller to any chain length, bit order and serial clock rate. It adds a completion strobe and optional OE brightness PWM. It sits between display/LED logic (e.g. hex display scanner) and the board pins.

## Interface
- CHAIN, 2: number of chained 595 devices, >=1; DW = 8*CHAIN (derived localparam)
- CLK_DIV, 4: clk cycles per SHCP half-period, >=1
- MSB_FIRST, 1: 1 = i_data[DW-1] shifted first; 0 = i_data[0] first
- PWM_W, 4: width of brightness duty input/counter
- clk  input  1  system clock, all logic on posedge
- rst_n  input  1  reset, synchronous, active-low
- i_data  input  DW  word to display; sampled only on handshake
- i_valid  input  1  i_data valid
- o_ready  output  1  high in IDLE; transfer when i_valid && o_ready
- o_done  output  1  one-cycle pulse when latch completes
- i_duty  input  PWM_W  brightness; used only with SR595_PWM_EN
- o_stcp  output  1  storage (latch) clock
- o_shcp  output  1  shift clock
- o_ds  output  1  serial data
- o_oe  output  1  output enable, active-low

## Operation
- FSM states: IDLE, SHIFT, LATCH.
- IDLE: o_ready=1, o_shcp=0, o_stcp=0. On i_valid && o_ready, capture i_data into DW-bit shift register, clear bit counter and divider, go SHIFT.
- SHIFT: per bit, o_ds holds current bit for 2*CLK_DIV cycles; o_shcp low first CLK_DIV cycles, high second CLK_DIV cycles. The 595 samples on the rising edge mid-bit. After bit DW-1 high phase, o_shcp returns low and the FSM goes to LATCH.
- Bit order: MSB_FIRST=1 shifts from [DW-1] down; 0 shifts from [0] up. The first bit shifted lands at the far end of the chain.
- LATCH: o_stcp high for CLK_DIV cycles, then IDLE with o_done=1 for one cycle.
- i_valid while not ready: ignored, no capture, no queuing. i_data changes during a transfer do not affect it.
- o_oe: 1 (outputs off) from reset until the first o_done. This blanks garbage after power-up. Afterwards behaviour follows Configuration.
- o_ds holds the last shifted bit in IDLE (don't-care to the bench except at reset).
- Reset (any state, incl. mid-SHIFT/LATCH): next cycle IDLE, counters cleared, first-latch flag cleared. o_stcp=0, o_shcp=0, o_ds=0, o_oe=1, o_done=0, o_ready=1. A partial word is abandoned; no latch pulse is generated.

## Timing
- All outputs registered except o_ready (decoded from IDLE state).
- Handshake edge = cycle 0. Bit i occupies cycles 1+2*CLK_DIV*i .. 2*CLK_DIV*(i+1). o_shcp rises at cycle 1+2*CLK_DIV*i+CLK_DIV.
- LATCH: o_stcp high cycles 1+2*CLK_DIV*DW .. 2*CLK_DIV*DW+CLK_DIV.
- o_done and o_ready high at cycle T = 1+(2*DW+1)*CLK_DIV. The next handshake is possible in the same cycle T.
- Defaults: DW=16, T=133. Throughput one word per T cycles with back-to-back i_valid.
- o_oe drops to 0 in cycle T of the first transfer (with o_done).

## Configuration
- SR595_PWM_EN defined: free-running PWM_W-bit counter from reset value 0. After first latch, o_oe = ~(cnt < i_duty), registered. i_duty=0 gives o_oe always 1; i_duty=2^PWM_W-1 gives low 2^PWM_W-1 of every 2^PWM_W cycles. i_duty is sampled each cycle.
- Undefined: no counter; i_duty ignored; o_oe=0 permanently after first latch.

## Test plan
- Reset, CHAIN=2, CLK_DIV=4, MSB_FIRST=1, send 16'hA5C3 -> DS sequence 1010010111000011 sampled at 16 SHCP rises; STCP high cycles 129-132; o_done and o_ready at cycle 133; o_oe 1 until 133, then 0.
- MSB_FIRST=0, CLK_DIV=1, send 16'h0001 -> first DS bit 1, then fifteen 0s; o_done at cycle 34.
- Hold i_valid with new data 16'hFFFF mid-transfer of 16'h0000 -> no capture until o_ready; second transfer starts at cycle 133 and shifts all 1s.
- Assert rst_n=0 during bit 7 -> next cycle all outputs at reset values, no STCP pulse; following send completes normally and o_oe stays 1 until its o_done.
- SR595_PWM_EN, PWM_W=4, i_duty=4 after first latch -> o_oe low exactly 4 of every 16 cycles; i_duty=0 -> o_oe constantly 1.
- CHAIN=3, CLK_DIV=2 -> 24 SHCP rises, o_done at cycle 1+49*2=99.

Source files
------------

// File: rtl/sr595_chain_ctrl.sv
// Daisy-chained 74HC595 driver: serialises a DW-bit word on DS/SHCP, pulses STCP, drives OE.
// Define SR595_PWM_EN to get OE brightness PWM driven by i_duty.
module sr595_chain_ctrl #(
    parameter int CHAIN     = 2,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1,
    parameter int PWM_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [8*CHAIN-1:0] i_data,
    input  logic               i_valid,
    output logic               o_ready,
    output logic               o_done,
    input  logic [PWM_W-1:0]   i_duty,
    output logic               o_stcp,
    output logic               o_shcp,
    output logic               o_ds,
    output logic               o_oe
);

    localparam int DW   = 8 * CHAIN;
    localparam int BITW = $clog2(DW);
    localparam int DIVW = $clog2(2 * CLK_DIV);
    localparam logic [BITW-1:0] BIT_LAST  = BITW'(DW - 1);
    localparam logic [DIVW-1:0] HALF_LAST = DIVW'(CLK_DIV - 1);
    localparam logic [DIVW-1:0] FULL_LAST = DIVW'(2 * CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     sr_q, sr_d;
    logic [BITW-1:0]   bit_q, bit_d;
    logic [DIVW-1:0]   div_q, div_d;
    logic              shcp_q, shcp_d;
    logic              stcp_q, stcp_d;
    logic              ds_q, ds_d;
    logic              done_q, done_d;
    logic              oe_q, oe_d;
    logic              first_q, first_d;

`ifdef SR595_PWM_EN
    logic [PWM_W-1:0]  cnt_q, cnt_d;
`else
    logic              unused_duty;
    assign unused_duty = ^i_duty;
`endif

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        div_d   = div_q;
        shcp_d  = shcp_q;
        stcp_d  = stcp_q;
        ds_d    = ds_q;
        done_d  = 1'b0;
        first_d = first_q;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    sr_d    = i_data;
                    ds_d    = (MSB_FIRST != 0) ? i_data[DW-1] : i_data[0];
                    bit_d   = '0;
                    div_d   = '0;
                    shcp_d  = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                div_d = div_q + 1'b1;
                if (div_q == HALF_LAST) begin
                    shcp_d = 1'b1;
                end
                // End of a bit period: drop SHCP and present the next bit, or move to latch.
                if (div_q == FULL_LAST) begin
                    div_d  = '0;
                    shcp_d = 1'b0;
                    if (bit_q == BIT_LAST) begin
                        stcp_d  = 1'b1;
                        state_d = LATCH;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        if (MSB_FIRST != 0) begin
                            sr_d = {sr_q[DW-2:0], 1'b0};
                            ds_d = sr_q[DW-2];
                        end else begin
                            sr_d = {1'b0, sr_q[DW-1:1]};
                            ds_d = sr_q[1];
                        end
                    end
                end
            end
            LATCH: begin
                div_d = div_q + 1'b1;
                if (div_q == HALF_LAST) begin
                    div_d   = '0;
                    stcp_d  = 1'b0;
                    done_d  = 1'b1;
                    first_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef SR595_PWM_EN
        cnt_d = cnt_q + 1'b1;
        oe_d  = first_d ? ~(cnt_q < i_duty) : 1'b1;
`else
        oe_d  = ~first_d;
`endif
    end

    // OE stays high (blanked) until the first complete word has been latched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            shcp_q  <= 1'b0;
            stcp_q  <= 1'b0;
            ds_q    <= 1'b0;
            done_q  <= 1'b0;
            oe_q    <= 1'b1;
            first_q <= 1'b0;
`ifdef SR595_PWM_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            shcp_q  <= shcp_d;
            stcp_q  <= stcp_d;
            ds_q    <= ds_d;
            done_q  <= done_d;
            oe_q    <= oe_d;
            first_q <= first_d;
`ifdef SR595_PWM_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_done  = done_q;
    assign o_stcp  = stcp_q;
    assign o_shcp  = shcp_q;
    assign o_ds    = ds_q;
    assign o_oe    = oe_q;

endmodule

// File: tb/tb_sr595_chain_ctrl.sv
// Directed testbench for sr595_chain_ctrl: three instances cover default, LSB-first/CLK_DIV=1
// and CHAIN=3 configurations; signals are driven and sampled on the falling clock edge.
module tb_sr595_chain_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  dutyTb = 4'd0;

    logic [15:0] dataA = '0;
    logic        validA = 1'b0;
    logic        readyA, doneA, stcpA, shcpA, dsA, oeA;
    logic [15:0] dataB = '0;
    logic        validB = 1'b0;
    logic        readyB, doneB, stcpB, shcpB, dsB, oeB;
    logic [23:0] dataC = '0;
    logic        validC = 1'b0;
    logic        readyC, doneC, stcpC, shcpC, dsC, oeC;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sr595_chain_ctrl #(.CHAIN(2), .CLK_DIV(4), .MSB_FIRST(1), .PWM_W(4)) dutA (
        .clk(clk), .rst_n(rst_n), .i_data(dataA), .i_valid(validA), .o_ready(readyA),
        .o_done(doneA), .i_duty(dutyTb), .o_stcp(stcpA), .o_shcp(shcpA), .o_ds(dsA), .o_oe(oeA));

    sr595_chain_ctrl #(.CHAIN(2), .CLK_DIV(1), .MSB_FIRST(0), .PWM_W(4)) dutB (
        .clk(clk), .rst_n(rst_n), .i_data(dataB), .i_valid(validB), .o_ready(readyB),
        .o_done(doneB), .i_duty(dutyTb), .o_stcp(stcpB), .o_shcp(shcpB), .o_ds(dsB), .o_oe(oeB));

    sr595_chain_ctrl #(.CHAIN(3), .CLK_DIV(2), .MSB_FIRST(1), .PWM_W(4)) dutC (
        .clk(clk), .rst_n(rst_n), .i_data(dataC), .i_valid(validC), .o_ready(readyC),
        .o_done(doneC), .i_duty(dutyTb), .o_stcp(stcpC), .o_shcp(shcpC), .o_ds(dsC), .o_oe(oeC));

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic startA(input logic [15:0] word);
        @(negedge clk);
        dataA  = word;
        validA = 1'b1;
        @(posedge clk);
        #1 validA = 1'b0;
    endtask

    // Follows one transfer of dutA from cycle 1 until o_done (or a 400-cycle bound).
    task automatic monitorA(output logic [15:0] seq, output int rises, output int firstStcp,
                            output int lastStcp, output int doneCyc, output int readyCount,
                            output bit oeEarlyLow);
        logic prev;
        prev = 1'b0; seq = '0; rises = 0; firstStcp = 0; lastStcp = 0;
        doneCyc = 0; readyCount = 0; oeEarlyLow = 1'b0;
        for (int n = 1; n <= 400 && doneCyc == 0; n++) begin
            @(negedge clk);
            if (shcpA && !prev) begin
                seq = {seq[14:0], dsA};
                rises++;
            end
            prev = shcpA;
            if (stcpA) begin
                if (firstStcp == 0) firstStcp = n;
                lastStcp = n;
            end
            if (readyA) readyCount++;
            if (doneA) doneCyc = n;
            else if (!oeA) oeEarlyLow = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (stcpA !== 1'b0) begin errors++; $display("[TB] FAIL reset_stcp: got %b expected 0", stcpA); end
        checks++; if (shcpA !== 1'b0) begin errors++; $display("[TB] FAIL reset_shcp: got %b expected 0", shcpA); end
        checks++; if (dsA !== 1'b0) begin errors++; $display("[TB] FAIL reset_ds: got %b expected 0", dsA); end
        checks++; if (oeA !== 1'b1) begin errors++; $display("[TB] FAIL reset_oe: got %b expected 1", oeA); end
        checks++; if (doneA !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", doneA); end
        checks++; if (readyA !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", readyA); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [15:0] seq;
        int rises, firstStcp, lastStcp, doneCyc, readyCount;
        bit oeEarlyLow;
        startA(16'hA5C3);
        monitorA(seq, rises, firstStcp, lastStcp, doneCyc, readyCount, oeEarlyLow);
        checks++; if (seq !== 16'hA5C3) begin errors++; $display("[TB] FAIL basic_ds_seq: got %h expected a5c3", seq); end
        checks++; if (rises != 16) begin errors++; $display("[TB] FAIL basic_shcp_rises: got %0d expected 16", rises); end
        checks++; if (firstStcp != 129) begin errors++; $display("[TB] FAIL basic_stcp_first: got %0d expected 129", firstStcp); end
        checks++; if (lastStcp != 132) begin errors++; $display("[TB] FAIL basic_stcp_last: got %0d expected 132", lastStcp); end
        checks++; if (doneCyc != 133) begin errors++; $display("[TB] FAIL basic_done_cycle: got %0d expected 133", doneCyc); end
        checks++; if (readyCount != 1) begin errors++; $display("[TB] FAIL basic_ready_count: got %0d expected 1", readyCount); end
        checks++; if (oeEarlyLow !== 1'b0) begin errors++; $display("[TB] FAIL basic_oe_early: got %b expected 0", oeEarlyLow); end
`ifndef SR595_PWM_EN
        checks++; if (oeA !== 1'b0) begin errors++; $display("[TB] FAIL basic_oe_at_done: got %b expected 0", oeA); end
`endif
    endtask

    task automatic test_back_to_back;
        logic [15:0] seq;
        int rises, firstStcp, lastStcp, doneCyc, readyCount;
        bit oeEarlyLow;
        @(negedge clk);
        dataA  = 16'h0000;
        validA = 1'b1;
        @(posedge clk);
        #1 dataA = 16'hFFFF;
        monitorA(seq, rises, firstStcp, lastStcp, doneCyc, readyCount, oeEarlyLow);
        checks++; if (seq !== 16'h0000) begin errors++; $display("[TB] FAIL b2b_first_seq: got %h expected 0000", seq); end
        checks++; if (doneCyc != 133) begin errors++; $display("[TB] FAIL b2b_first_done: got %0d expected 133", doneCyc); end
        checks++; if (readyCount != 1) begin errors++; $display("[TB] FAIL b2b_ready_count: got %0d expected 1", readyCount); end
        @(posedge clk);
        #1 validA = 1'b0;
        monitorA(seq, rises, firstStcp, lastStcp, doneCyc, readyCount, oeEarlyLow);
        checks++; if (seq !== 16'hFFFF) begin errors++; $display("[TB] FAIL b2b_second_seq: got %h expected ffff", seq); end
        checks++; if (doneCyc != 133) begin errors++; $display("[TB] FAIL b2b_second_done: got %0d expected 133", doneCyc); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] seq;
        int rises, firstStcp, lastStcp, doneCyc, readyCount, spurious;
        bit oeEarlyLow;
        startA(16'h1234);
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (shcpA !== 1'b0) begin errors++; $display("[TB] FAIL midrst_shcp: got %b expected 0", shcpA); end
        checks++; if (stcpA !== 1'b0) begin errors++; $display("[TB] FAIL midrst_stcp: got %b expected 0", stcpA); end
        checks++; if (dsA !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ds: got %b expected 0", dsA); end
        checks++; if (oeA !== 1'b1) begin errors++; $display("[TB] FAIL midrst_oe: got %b expected 1", oeA); end
        checks++; if (readyA !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready: got %b expected 1", readyA); end
        rst_n = 1'b1;
        spurious = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (stcpA || doneA) spurious++;
        end
        checks++; if (spurious != 0) begin errors++; $display("[TB] FAIL midrst_no_latch: got %0d expected 0", spurious); end
        startA(16'h3C5A);
        monitorA(seq, rises, firstStcp, lastStcp, doneCyc, readyCount, oeEarlyLow);
        checks++; if (seq !== 16'h3C5A) begin errors++; $display("[TB] FAIL midrst_seq: got %h expected 3c5a", seq); end
        checks++; if (doneCyc != 133) begin errors++; $display("[TB] FAIL midrst_done: got %0d expected 133", doneCyc); end
        checks++; if (oeEarlyLow !== 1'b0) begin errors++; $display("[TB] FAIL midrst_oe_early: got %b expected 0", oeEarlyLow); end
    endtask

    task automatic test_lsb_first;
        logic [15:0] seq;
        logic prev;
        int rises, doneCyc;
        seq = '0; prev = 1'b0; rises = 0; doneCyc = 0;
        @(negedge clk);
        dataB  = 16'h0001;
        validB = 1'b1;
        @(posedge clk);
        #1 validB = 1'b0;
        for (int n = 1; n <= 100 && doneCyc == 0; n++) begin
            @(negedge clk);
            if (shcpB && !prev) begin
                seq = {seq[14:0], dsB};
                rises++;
            end
            prev = shcpB;
            if (doneB) doneCyc = n;
        end
        checks++; if (seq !== 16'h8000) begin errors++; $display("[TB] FAIL lsb_seq: got %h expected 8000", seq); end
        checks++; if (rises != 16) begin errors++; $display("[TB] FAIL lsb_rises: got %0d expected 16", rises); end
        checks++; if (doneCyc != 34) begin errors++; $display("[TB] FAIL lsb_done: got %0d expected 34", doneCyc); end
    endtask

    task automatic test_chain3;
        logic [23:0] seq;
        logic prev;
        int rises, doneCyc;
        seq = '0; prev = 1'b0; rises = 0; doneCyc = 0;
        @(negedge clk);
        dataC  = 24'hC3A55A;
        validC = 1'b1;
        @(posedge clk);
        #1 validC = 1'b0;
        for (int n = 1; n <= 200 && doneCyc == 0; n++) begin
            @(negedge clk);
            if (shcpC && !prev) begin
                seq = {seq[22:0], dsC};
                rises++;
            end
            prev = shcpC;
            if (doneC) doneCyc = n;
        end
        checks++; if (seq !== 24'hC3A55A) begin errors++; $display("[TB] FAIL chain3_seq: got %h expected c3a55a", seq); end
        checks++; if (rises != 24) begin errors++; $display("[TB] FAIL chain3_rises: got %0d expected 24", rises); end
        checks++; if (doneCyc != 99) begin errors++; $display("[TB] FAIL chain3_done: got %0d expected 99", doneCyc); end
    endtask

    task automatic test_oe_after_latch;
        int lows;
`ifdef SR595_PWM_EN
        @(negedge clk);
        dutyTb = 4'd4;
        repeat (2) @(negedge clk);
        lows = 0;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (!oeA) lows++;
        end
        checks++; if (lows != 4) begin errors++; $display("[TB] FAIL pwm_duty4: got %0d expected 4", lows); end
        dutyTb = 4'd15;
        repeat (2) @(negedge clk);
        lows = 0;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (!oeA) lows++;
        end
        checks++; if (lows != 15) begin errors++; $display("[TB] FAIL pwm_duty15: got %0d expected 15", lows); end
        dutyTb = 4'd0;
        repeat (2) @(negedge clk);
        lows = 0;
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            if (!oeA) lows++;
        end
        checks++; if (lows != 0) begin errors++; $display("[TB] FAIL pwm_duty0: got %0d expected 0", lows); end
`else
        dutyTb = 4'd4;
        lows = 0;
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            if (!oeA) lows++;
        end
        checks++; if (lows != 32) begin errors++; $display("[TB] FAIL oe_steady_low: got %0d expected 32", lows); end
`endif
    endtask

    initial begin
        $display("[TB] starting sr595_chain_ctrl bench");
        test_reset;
        test_basic;
        test_oe_after_latch;
        test_back_to_back;
        test_reset_mid;
        test_lsb_first;
        test_chain3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
